// File: rtl/morse_pkg.sv
// Shared definitions for the morse transmitter write-port arbiter:
// FSM encodings, the default gap byte and the index-width helper.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Grant index width; a single requester still needs one bit.
  function automatic int idxw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request after
// ptr (circular), plus a flag saying whether any request is set.
module rr_pick
  import morse_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idxw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any_valid
);

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx       = IDXW'((int'(ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_tx_arbiter.sv
// Round-robin arbiter in front of the morse transmitter byte-write port.
// A grant lasts a whole message; MORSE_ARB_GAP_EN adds a gap byte after each.
//
// Handshake: a beat on source i happens on a rising edge where
// req_valid[i] & req_ready[i]; a source must hold data/last stable while
// valid is high and not yet accepted. tx_write_en is a single-cycle strobe
// qualified by !tx_full.
module morse_tx_arbiter
  import morse_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_STALL = 1023
`ifdef MORSE_ARB_GAP_EN
  , parameter logic [7:0] GAP_CHAR = ASCII_SPACE
`endif
  , localparam int IDXW   = idxw(NREQ)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_write_en,
  output logic [7:0]        tx_ascii,
  input  logic              tx_full,
  output logic [IDXW-1:0]   grant_idx,
  output logic              busy,
  output logic              stall_err,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(MAX_STALL + 1);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            g_valid, g_last, beat;
  logic [7:0]      g_data;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign g_data  = req_data[8*int'(grant_q) +: 8];
  assign beat    = (state_q == ST_GRANT) && g_valid && !tx_full;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= IDXW'(NREQ - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    stall_d     = stall_q;
    req_ready   = '0;
    tx_write_en = 1'b0;
    tx_ascii    = '0;
    stall_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[grant_q] = !tx_full;
        tx_write_en        = g_valid && !tx_full;
        tx_ascii           = g_data;
        if (beat) begin
          stall_d = '0;
          if (g_last) begin
            rr_d    = grant_q;
`ifdef MORSE_ARB_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_IDLE;
`endif
          end
        end else if (!g_valid) begin
          // The idle cycle that brings the count to MAX_STALL revokes the grant.
          if (stall_q == CW'(MAX_STALL - 1)) begin
            stall_err = 1'b1;
            rr_d      = grant_q;
            stall_d   = '0;
            state_d   = ST_IDLE;
          end else begin
            stall_d = stall_q + CW'(1);
          end
        end
      end
`ifdef MORSE_ARB_GAP_EN
      ST_GAP: begin
        tx_write_en = !tx_full;
        tx_ascii    = GAP_CHAR;
        if (!tx_full) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Self-checking bench for morse_tx_arbiter (NREQ=4, MAX_STALL=8); gap
// expectations follow MORSE_ARB_GAP_EN.
module tb_morse_tx_arbiter;
  import morse_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_STALL = 8;
  localparam int IDXW      = 2;

  logic              clk = 1'b0;
  logic              arst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [8*NREQ-1:0] req_data;
  logic              tx_write_en, tx_full;
  logic [7:0]        tx_ascii;
  logic [IDXW-1:0]   grant_idx;
  logic              busy, stall_err;
  logic [1:0]        state_dbg;

  logic       src_valid [NREQ];
  logic       src_last  [NREQ];
  logic [7:0] src_data  [NREQ];

  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         stall_seen = 0;

  typedef struct {
    logic [NREQ-1:0] mask;
    int              exp_g;
  } arb_vec_t;
  arb_vec_t vecs[12];

  morse_tx_arbiter #(.NREQ(NREQ), .MAX_STALL(MAX_STALL)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_write_en (tx_write_en),
    .tx_ascii    (tx_ascii),
    .tx_full     (tx_full),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .stall_err   (stall_err),
    .state_dbg   (state_dbg)
  );

  // clock / packing
  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = src_valid[i];
      req_last[i]       = src_last[i];
      req_data[8*i +: 8] = src_data[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every FIFO write must match the head of exp_q
  always @(negedge clk) begin
    if (arst === 1'b0 && stall_err === 1'b1) stall_seen++;
    if (arst === 1'b0 && tx_write_en === 1'b1) begin
      check("write_while_full", {31'd0, tx_full}, 32'd0);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_unexpected: got %0h expected no write", tx_ascii);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_ascii !== e) begin
          n_fail++;
          $display("FAIL fifo_byte: got %0h expected %0h", tx_ascii, e);
        end
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_gap();
`ifdef MORSE_ARB_GAP_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NREQ; i++) begin
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
      src_data[i]  = 8'h00;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    clear_srcs();
    tx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check("reach_idle", {31'd0, busy}, 32'd0);
  endtask

  // driver: sends one message on source s, holding each byte until accepted
  task automatic send_msg(input int s, input string msg, input bit with_last);
    for (int i = 0; i < msg.len(); i++) begin
      bit got;
      int budget;
      src_valid[s] = 1'b1;
      src_data[s]  = msg[i];
      src_last[s]  = with_last && (i == msg.len() - 1);
      got = 1'b0;
      budget = 0;
      while (!got && budget < 300) begin
        @(negedge clk);
        got = (req_ready[s] === 1'b1);
        @(posedge clk);
        #1 budget++;
      end
      if (!got) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: src%0d byte %0d not accepted", s, i);
      end
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0101, 0};
    vecs[1]  = '{4'b0101, 2};
    vecs[2]  = '{4'b0101, 0};
    vecs[3]  = '{4'b1000, 3};
    vecs[4]  = '{4'b1111, 0};
    vecs[5]  = '{4'b1111, 1};
    vecs[6]  = '{4'b0001, 0};
    vecs[7]  = '{4'b1110, 1};
    vecs[8]  = '{4'b0110, 2};
    vecs[9]  = '{4'b0010, 1};
    vecs[10] = '{4'b1001, 3};
    vecs[11] = '{4'b1001, 0};

    // 1: reset mid-GRANT clears outputs immediately
    do_reset();
    tx_full = 1'b1;
    src_valid[1] = 1'b1;
    src_data[1]  = "Q";
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_grant", {30'd0, grant_idx}, 32'd1);
    check("full_ready", {28'd0, req_ready}, 32'd0);
    arst = 1'b1;
    #1;
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_wen", {31'd0, tx_write_en}, 32'd0);
    check("rst_ascii", {24'd0, tx_ascii}, 32'd0);
    check("rst_grant", {30'd0, grant_idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_err}, 32'd0);
    clear_srcs();
    tx_full = 1'b0;
    @(posedge clk);
    #1 arst = 1'b0;

    // table: single-byte messages, check round-robin choice
    for (int v = 0; v < 12; v++) begin
      wait_idle();
      exp_q.push_back(8'h30 + 8'(vecs[v].exp_g));
      push_gap();
      for (int i = 0; i < NREQ; i++) begin
        src_valid[i] = vecs[v].mask[i];
        src_last[i]  = 1'b1;
        src_data[i]  = 8'h30 + 8'(i);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_grant", v), {30'd0, grant_idx}, vecs[v].exp_g);
      check($sformatf("vec%0d_ready", v), {28'd0, req_ready}, 32'd1 << vecs[v].exp_g);
      check($sformatf("vec%0d_wen", v), {31'd0, tx_write_en}, 32'd1);
      @(posedge clk);
      #1 clear_srcs();
    end
    wait_idle();

    // 2: four concurrent 2-byte messages, no interleaving
    do_reset();
    for (int s = 0; s < NREQ; s++) begin
      push_str($sformatf("%c%c", 8'h41 + 8'(2*s), 8'h42 + 8'(2*s)));
      push_gap();
    end
    fork
      send_msg(0, "AB", 1'b1);
      send_msg(1, "CD", 1'b1);
      send_msg(2, "EF", 1'b1);
      send_msg(3, "GH", 1'b1);
    join
    wait_idle();

    // 3: backpressure mid-message
    do_reset();
    push_str("PQRS");
    push_gap();
    fork
      send_msg(0, "PQRS", 1'b1);
      begin
        int seen;
        seen = 0;
        for (int n = 0; n < 50 && seen < 2; n++) begin
          @(negedge clk);
          if (tx_write_en === 1'b1) seen++;
        end
        check("bp_two_writes", seen, 2);
        @(posedge clk);
        #1 tx_full = 1'b1;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          check("bp_wen", {31'd0, tx_write_en}, 32'd0);
          check("bp_ready", {28'd0, req_ready}, 32'd0);
          @(posedge clk);
        end
        #1 tx_full = 1'b0;
      end
    join
    wait_idle();
    check("bp_no_stall", stall_seen, 0);

    // 4: stall watchdog revokes src1, src2 granted next
    do_reset();
    push_str("XZ");
    push_gap();
    src_valid[2] = 1'b1;
    src_data[2]  = "Z";
    src_last[2]  = 1'b1;
    send_msg(1, "X", 1'b0);
    for (int k = 1; k <= MAX_STALL; k++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d", k), {31'd0, stall_err}, (k == MAX_STALL) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("revoke_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("after_revoke_grant", {30'd0, grant_idx}, 32'd2);
    check("after_revoke_wen", {31'd0, tx_write_en}, 32'd1);
    @(posedge clk);
    #1 clear_srcs();
    wait_idle();
    check("stall_pulses", stall_seen, 1);

    // 5: last beat on the cycle the count would hit MAX_STALL
    do_reset();
    push_str("MN");
    push_gap();
    send_msg(0, "M", 1'b0);
    for (int k = 1; k < MAX_STALL; k++) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    src_valid[0] = 1'b1;
    src_data[0]  = "N";
    src_last[0]  = 1'b1;
    @(negedge clk);
    check("race_stall", {31'd0, stall_err}, 32'd0);
    check("race_wen", {31'd0, tx_write_en}, 32'd1);
    @(posedge clk);
    #1 clear_srcs();
    wait_idle();
    check("race_pulses", stall_seen, 1);

`ifdef MORSE_ARB_GAP_EN
    // 6: gap byte held while FIFO full
    do_reset();
    push_str("HI OK ");
    fork
      send_msg(0, "HI", 1'b1);
      send_msg(1, "OK", 1'b1);
      begin
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (tx_write_en === 1'b1 && tx_ascii === 8'h49) break;
        end
        @(posedge clk);
        #1 tx_full = 1'b1;
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          check("gap_state", {30'd0, state_dbg}, {30'd0, ST_GAP});
          check("gap_hold_wen", {31'd0, tx_write_en}, 32'd0);
          check("gap_hold_ascii", {24'd0, tx_ascii}, 32'h20);
          @(posedge clk);
        end
        #1 tx_full = 1'b0;
      end
    join
    wait_idle();
`endif

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
